clock_hands_gen: RTL

//  Wall-clock time base feeding the hour/minute/second hand tiles of the VGA clock face.
//  - Counts frame ticks from the VGA timing stage (one per frame, at the restart point).
//  - Keeps time as hh:mm:ss and derives 0..59 hand positions.
//  - Offers a position snapshot over a valid/ready handshake to the tile-coefficient loader downstream.

---
 rtl/clock_hands_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/clock_hands_gen.sv
// Wall-clock time base for the VGA clock-face hand tiles: frame ticks -> hh:mm:ss -> hand positions.
// Optional CLOCK_HANDS_FAST_EN adds i_fast, making every frame tick a second elapse.
module clock_hands_gen #(
    parameter int unsigned FRAMES_PER_SEC = 75,
    parameter int unsigned FRAME_CNT_W    = 7
) (
    input  logic       i_vga_clk,
    input  logic       i_rst_n,
    input  logic       i_frame_tick,
`ifdef CLOCK_HANDS_FAST_EN
    input  logic       i_fast,
`endif
    input  logic       i_set_valid,
    input  logic [3:0] i_set_hour,
    input  logic [5:0] i_set_min,
    input  logic [5:0] i_set_sec,
    output logic       o_set_err,
    output logic [3:0] o_hour,
    output logic [5:0] o_min,
    output logic [5:0] o_sec,
    output logic       o_upd_valid,
    input  logic       i_upd_ready,
    output logic [5:0] o_hour_pos,
    output logic [5:0] o_min_pos,
    output logic [5:0] o_sec_pos
);

    localparam logic [FRAME_CNT_W-1:0] LastFrame = FRAME_CNT_W'(FRAMES_PER_SEC - 1);

    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic [3:0]             r_hour;
    logic [5:0]             r_min;
    logic [5:0]             r_sec;
    logic [5:0]             r_hour_pos;
    logic [5:0]             r_min_pos;
    logic [5:0]             r_sec_pos;
    logic                   r_upd_valid;
    logic                   r_set_err;

    logic                   w_fast;
    logic                   w_set_ok;
    logic                   w_set_bad;
    logic                   w_sec_elapse;
    logic                   w_recompute;
    logic [FRAME_CNT_W-1:0] w_frame_n;
    logic [3:0]             w_hour_n;
    logic [5:0]             w_min_n;
    logic [5:0]             w_sec_n;
    logic [2:0]             w_min_div12;
    logic [5:0]             w_hour_x5;
    logic [5:0]             w_hour_pos_n;

`ifdef CLOCK_HANDS_FAST_EN
    assign w_fast = i_fast;
`else
    assign w_fast = 1'b0;
`endif

    assign w_set_ok     = i_set_valid && (i_set_hour <= 4'd11) && (i_set_min <= 6'd59)
                          && (i_set_sec <= 6'd59);
    assign w_set_bad    = i_set_valid && !w_set_ok;
    assign w_sec_elapse = i_frame_tick && (w_fast || (r_frame_cnt == LastFrame));
    // An accepted set overrides a coincident second elapse; both refresh the snapshot.
    assign w_recompute  = w_set_ok || w_sec_elapse;

    always_comb begin
        w_frame_n = r_frame_cnt;
        w_hour_n  = r_hour;
        w_min_n   = r_min;
        w_sec_n   = r_sec;
        if (w_set_ok) begin
            w_frame_n = '0;
            w_hour_n  = i_set_hour;
            w_min_n   = i_set_min;
            w_sec_n   = i_set_sec;
        end else if (w_sec_elapse) begin
            w_frame_n = '0;
            if (r_sec == 6'd59) begin
                w_sec_n = 6'd0;
                if (r_min == 6'd59) begin
                    w_min_n  = 6'd0;
                    w_hour_n = (r_hour == 4'd11) ? 4'd0 : r_hour + 4'd1;
                end else begin
                    w_min_n = r_min + 6'd1;
                end
            end else begin
                w_sec_n = r_sec + 6'd1;
            end
        end else if (w_fast) begin
            w_frame_n = '0;
        end else if (i_frame_tick) begin
            w_frame_n = r_frame_cnt + 1'b1;
        end
    end

    always_comb begin
        if (w_min_n >= 6'd48)      w_min_div12 = 3'd4;
        else if (w_min_n >= 6'd36) w_min_div12 = 3'd3;
        else if (w_min_n >= 6'd24) w_min_div12 = 3'd2;
        else if (w_min_n >= 6'd12) w_min_div12 = 3'd1;
        else                       w_min_div12 = 3'd0;
    end

    assign w_hour_x5    = {w_hour_n, 2'b00} + {2'b00, w_hour_n};
    assign w_hour_pos_n = w_hour_x5 + {3'b000, w_min_div12};

    always_ff @(posedge i_vga_clk) begin
        if (!i_rst_n) begin
            r_frame_cnt <= '0;
            r_hour      <= 4'd0;
            r_min       <= 6'd0;
            r_sec       <= 6'd0;
            r_hour_pos  <= 6'd0;
            r_min_pos   <= 6'd0;
            r_sec_pos   <= 6'd0;
            r_upd_valid <= 1'b1;
            r_set_err   <= 1'b0;
        end else begin
            r_frame_cnt <= w_frame_n;
            r_hour      <= w_hour_n;
            r_min       <= w_min_n;
            r_sec       <= w_sec_n;
            r_set_err   <= w_set_bad;
            if (w_recompute) begin
                r_hour_pos  <= w_hour_pos_n;
                r_min_pos   <= w_min_n;
                r_sec_pos   <= w_sec_n;
                r_upd_valid <= 1'b1;
            end else if (r_upd_valid && i_upd_ready) begin
                r_upd_valid <= 1'b0;
            end
        end
    end

    assign o_set_err   = r_set_err;
    assign o_hour      = r_hour;
    assign o_min       = r_min;
    assign o_sec       = r_sec;
    assign o_upd_valid = r_upd_valid;
    assign o_hour_pos  = r_hour_pos;
    assign o_min_pos   = r_min_pos;
    assign o_sec_pos   = r_sec_pos;

endmodule
